// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass, busy-bit scoreboard
// and a multi-cycle sequential clear sweep.
module register_file_sb #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int AW      = 5,
  parameter int ZERO_R0 = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             rbusy1,
  output logic             rbusy2,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             write,
  input  logic             reserve,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             clear,
  output logic             ready
);

  localparam int IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit ZR  = (ZERO_R0 != 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [IDX-1:0]   r_cnt;
  logic             r_ready;

  logic [IDX-1:0] w_ridx1;
  logic [IDX-1:0] w_ridx2;
  logic [IDX-1:0] w_widx;
  logic [IDX-1:0] w_sidx;
  logic           w_idle;
  logic           w_wrEn;
  logic           w_rsvEn;
  logic           w_hit1;
  logic           w_hit2;
  logic           w_zero1;
  logic           w_zero2;

  assign w_ridx1 = raddr1[IDX-1:0];
  assign w_ridx2 = raddr2[IDX-1:0];
  assign w_widx  = waddr[IDX-1:0];
  assign w_sidx  = rsv_addr[IDX-1:0];
  assign w_idle  = (r_state == IDLE);

  // Writes and reserves aimed at a hardwired-zero r0 are dropped entirely,
  // so r0 stays 0 and never becomes busy.
  assign w_wrEn  = write   && w_idle && !(ZR && (w_widx == '0));
  assign w_rsvEn = reserve && w_idle && !(ZR && (w_sidx == '0));

  assign w_hit1  = w_wrEn && (w_widx == w_ridx1);
  assign w_hit2  = w_wrEn && (w_widx == w_ridx2);
  assign w_zero1 = ZR && (w_ridx1 == '0);
  assign w_zero2 = ZR && (w_ridx2 == '0);

  // An in-flight writeback both forwards its data and hides the hazard.
  assign rdata1 = w_zero1 ? '0 : (w_hit1 ? wdata : r_regs[w_ridx1]);
  assign rdata2 = w_zero2 ? '0 : (w_hit2 ? wdata : r_regs[w_ridx2]);
  assign rbusy1 = !w_zero1 && r_busy[w_ridx1] && !w_hit1;
  assign rbusy2 = !w_zero2 && r_busy[w_ridx2] && !w_hit2;
  assign ready  = r_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wrEn) begin
            r_regs[w_widx] <= wdata;
            r_busy[w_widx] <= 1'b0;
          end
          // Placed after the write so a same-index reserve leaves the bit set.
          if (w_rsvEn) r_busy[w_sidx] <= 1'b1;
          if (clear) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
        CLEAR: begin
          r_regs[r_cnt] <= '0;
          r_busy[r_cnt] <= 1'b0;
          if (r_cnt == IDX'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (AW > IDX) begin : gUnusedAddr
      logic w_unused;
      assign w_unused = &{1'b0, raddr1[AW-1:IDX], raddr2[AW-1:IDX],
                          waddr[AW-1:IDX], rsv_addr[AW-1:IDX]};
    end
  endgenerate

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus randomized traffic,
// both checked against an array-based reference model of the register file.
module tb_register_file_sb;

  logic        clock;
  logic        reset;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        write;
  logic        reserve;
  logic [4:0]  rsv_addr;
  logic        clear;

  logic [31:0] rdata1, rdata2, rdata1Z, rdata2Z;
  logic        rbusy1, rbusy2, rbusy1Z, rbusy2Z;
  logic        ready, readyZ;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: index 0 tracks the plain DUT, index 1 the zero-r0 DUT.
  logic [31:0] mReg  [2][8];
  logic        mBusy [2][8];
  int          mSweep;

  register_file_sb #(.WIDTH(32), .DEPTH(8), .AW(5), .ZERO_R0(0)) dut (
    .clock(clock), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .rbusy1(rbusy1), .rbusy2(rbusy2),
    .waddr(waddr), .wdata(wdata), .write(write),
    .reserve(reserve), .rsv_addr(rsv_addr),
    .clear(clear), .ready(ready)
  );

  register_file_sb #(.WIDTH(32), .DEPTH(8), .AW(5), .ZERO_R0(1)) dutZ (
    .clock(clock), .reset(reset),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1Z), .rdata2(rdata2Z),
    .rbusy1(rbusy1Z), .rbusy2(rbusy2Z),
    .waddr(waddr), .wdata(wdata), .write(write),
    .reserve(reserve), .rsv_addr(rsv_addr),
    .clear(clear), .ready(readyZ)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void modelReset();
    for (int z = 0; z < 2; z++)
      for (int i = 0; i < 8; i++) begin
        mReg[z][i]  = '0;
        mBusy[z][i] = 1'b0;
      end
    mSweep = -1;
  endfunction

  function automatic void modelEdge();
    int wi;
    int ri;
    wi = int'(waddr[2:0]);
    ri = int'(rsv_addr[2:0]);
    if (mSweep >= 0) begin
      for (int z = 0; z < 2; z++) begin
        mReg[z][mSweep]  = '0;
        mBusy[z][mSweep] = 1'b0;
      end
      mSweep++;
      if (mSweep == 8) mSweep = -1;
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (write && !(z == 1 && wi == 0)) begin
          mReg[z][wi]  = wdata;
          mBusy[z][wi] = 1'b0;
        end
        if (reserve && !(z == 1 && ri == 0)) mBusy[z][ri] = 1'b1;
      end
      if (clear) mSweep = 0;
    end
  endfunction

  function automatic void expRead(input int z, input logic [4:0] a,
                                  output logic [31:0] d, output logic b);
    int   idx;
    int   wi;
    logic hit;
    idx = int'(a[2:0]);
    wi  = int'(waddr[2:0]);
    if (z == 1 && idx == 0) begin
      d = '0;
      b = 1'b0;
    end else begin
      hit = write && (mSweep < 0) && (wi == idx);
      d   = hit ? wdata : mReg[z][idx];
      b   = mBusy[z][idx] && !hit;
    end
  endfunction

  function automatic void getObs(input int z, input int p,
                                 output logic [31:0] d, output logic b);
    case ({z[0], p[0]})
      2'b00:   begin d = rdata1;  b = rbusy1;  end
      2'b01:   begin d = rdata2;  b = rbusy2;  end
      2'b10:   begin d = rdata1Z; b = rbusy1Z; end
      default: begin d = rdata2Z; b = rbusy2Z; end
    endcase
  endfunction

  // Advance one clock: the model sees the inputs held across the edge.
  task automatic tick();
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic applyIdle();
    write    = 1'b0;
    reserve  = 1'b0;
    clear    = 1'b0;
    waddr    = '0;
    wdata    = '0;
    rsv_addr = '0;
    raddr1   = '0;
    raddr2   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyIdle();
    modelReset();
    #2;
    compared++;
    if (ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b, expected 1", ready);
    end
    for (int j = 0; j < 8; j++) begin
      raddr1 = 5'(j);
      #1;
      compared++;
      if (rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_r%0d: got %h/%b, expected 0/0", j, rdata1, rbusy1);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_rw();
    write = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    tick();
    write = 1'b0; raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    compared++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      mismatched++;
      $display("[TB] FAIL rw_r3: got %h/%h, expected deadbeef", rdata1, rdata2);
    end
    reset = 1'b1;
    modelReset();
    #1;
    compared++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rw_async_reset: got %h/%h, expected 0", rdata1, rdata2);
    end
    @(negedge clock);
    reset = 1'b0;
    applyIdle();
    tick();
  endtask

  task automatic test_bypass();
    write = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr1 = 5'd5;
    #1;
    compared++;
    if (rdata1 !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL bypass: got %h, expected 12345678", rdata1);
    end
    raddr1 = 5'h1D;
    #1;
    compared++;
    if (rdata1 !== 32'h12345678) begin
      mismatched++;
      $display("[TB] FAIL bypass_trunc: got %h, expected 12345678", rdata1);
    end
    tick();
    applyIdle();
  endtask

  task automatic test_scoreboard();
    reserve = 1'b1; rsv_addr = 5'd2;
    tick();
    reserve = 1'b0; raddr1 = 5'd2;
    #1;
    compared++;
    if (rbusy1 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sb_reserved: got %b, expected 1", rbusy1);
    end
    write = 1'b1; waddr = 5'd2; wdata = 32'h0BADF00D;
    #1;
    compared++;
    if (rbusy1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sb_hidden: got %b, expected 0", rbusy1);
    end
    tick();
    write = 1'b0;
    #1;
    compared++;
    if (rbusy1 !== 1'b0 || rdata1 !== 32'h0BADF00D) begin
      mismatched++;
      $display("[TB] FAIL sb_written: got %b/%h, expected 0/0badf00d", rbusy1, rdata1);
    end
    write = 1'b1; wdata = 32'hCAFE0002; reserve = 1'b1; rsv_addr = 5'd2;
    tick();
    applyIdle();
    raddr1 = 5'd2;
    #1;
    compared++;
    if (rbusy1 !== 1'b1 || rdata1 !== 32'hCAFE0002) begin
      mismatched++;
      $display("[TB] FAIL sb_rsv_wins: got %b/%h, expected 1/cafe0002", rbusy1, rdata1);
    end
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; waddr = 5'(i); wdata = 32'hFFFFFFFF;
      tick();
    end
    applyIdle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        raddr1 = 5'd2; raddr2 = 5'd3;
        write = 1'b1; waddr = 5'd7; wdata = 32'h00C0FFEE;
        clear = 1'b1;
        #1;
        compared++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'hFFFFFFFF) begin
          mismatched++;
          $display("[TB] FAIL sweep_partial: got %h/%h, expected 0/ffffffff", rdata1, rdata2);
        end
      end else if (k == 4) begin
        raddr1 = 5'd7; raddr2 = 5'd0;
        #1;
        compared++;
        if (rdata1 !== 32'hFFFFFFFF || rdata2 !== 32'h0) begin
          mismatched++;
          $display("[TB] FAIL sweep_write_dropped: got %h/%h, expected ffffffff/0", rdata1, rdata2);
        end
      end else begin
        #1;
      end
      compared++;
      if (ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL sweep_ready_low_%0d: got %b, expected 0", k, ready);
      end
      tick();
      applyIdle();
    end
    compared++;
    if (ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sweep_ready_back: got %b, expected 1", ready);
    end
    for (int j = 0; j < 8; j++) begin
      raddr1 = 5'(j);
      @(negedge clock);
      compared++;
      if (rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL sweep_end_r%0d: got %h/%b, expected 0/0", j, rdata1, rbusy1);
      end
    end
    tick();
  endtask

  task automatic test_zero_r0();
    write = 1'b1; waddr = 5'd0; wdata = 32'hAAAAAAAA;
    reserve = 1'b1; rsv_addr = 5'd0; raddr1 = 5'd0;
    #1;
    compared++;
    if (rdata1Z !== 32'h0 || rbusy1Z !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_r0_bypass: got %h/%b, expected 0/0", rdata1Z, rbusy1Z);
    end
    compared++;
    if (rdata1 !== 32'hAAAAAAAA) begin
      mismatched++;
      $display("[TB] FAIL r0_plain_bypass: got %h, expected aaaaaaaa", rdata1);
    end
    tick();
    write = 1'b0; reserve = 1'b0;
    #1;
    compared++;
    if (rdata1Z !== 32'h0 || rbusy1Z !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL zero_r0_after: got %h/%b, expected 0/0", rdata1Z, rbusy1Z);
    end
    compared++;
    if (rdata1 !== 32'hAAAAAAAA || rbusy1 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL r0_plain_after: got %h/%b, expected aaaaaaaa/1", rdata1, rbusy1);
    end
    applyIdle();
  endtask

  task automatic test_reset_mid_sweep();
    int lowCycles;
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; waddr = 5'(i); wdata = $urandom | 32'h1;
      reserve = 1'b1; rsv_addr = 5'(i);
      tick();
    end
    applyIdle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    raddr1 = 5'd6;
    reset = 1'b1;
    modelReset();
    #1;
    compared++;
    if (ready !== 1'b1 || rdata1 !== 32'h0 || rbusy1 !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midsweep_reset: got %b/%h/%b, expected 1/0/0", ready, rdata1, rbusy1);
    end
    for (int j = 0; j < 8; j++) begin
      raddr2 = 5'(j);
      @(negedge clock);
      compared++;
      if (rdata2 !== 32'h0 || rbusy2 !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL midsweep_r%0d: got %h/%b, expected 0/0", j, rdata2, rbusy2);
      end
    end
    reset = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    lowCycles = 0;
    for (int guard = 0; guard < 20; guard++) begin
      if (ready !== 1'b0) break;
      lowCycles++;
      tick();
    end
    compared++;
    if (lowCycles != 8) begin
      mismatched++;
      $display("[TB] FAIL resweep_len: got %0d cycles, expected 8", lowCycles);
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic [31:0] od;
    logic        eb;
    logic        ob;
    for (int c = 0; c < 400; c++) begin
      write    = 1'($urandom_range(0, 1));
      reserve  = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 24) == 0);
      waddr    = 5'($urandom);
      wdata    = $urandom;
      rsv_addr = 5'($urandom);
      raddr1   = 5'($urandom);
      raddr2   = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom);
      #1;
      for (int z = 0; z < 2; z++) begin
        for (int p = 0; p < 2; p++) begin
          expRead(z, (p == 0) ? raddr1 : raddr2, ed, eb);
          getObs(z, p, od, ob);
          compared++;
          if (od !== ed || ob !== eb) begin
            mismatched++;
            $display("[TB] FAIL rand_z%0d_p%0d cyc %0d: got %h/%b, expected %h/%b",
                     z, p, c, od, ob, ed, eb);
          end
        end
      end
      compared++;
      if (ready !== (mSweep < 0) || readyZ !== (mSweep < 0)) begin
        mismatched++;
        $display("[TB] FAIL rand_ready cyc %0d: got %b/%b, expected %b",
                 c, ready, readyZ, (mSweep < 0));
      end
      tick();
    end
    applyIdle();
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_bypass();
    test_scoreboard();
    test_clear_sweep();
    test_zero_r0();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
